vga_ctrl_apb: RTL and testbench
===============================

Name: vga_ctrl_apb

Overview:
- Parametrised VGA timing and pixel controller with an APB3 slave control port.
- Successor to the fixed-640x480 APB VGA block: programmable timing and sync polarity, three pixel sources, FIFO-fed pixel streaming, and frame/underflow status.
- Sits on the SoC APB peripheral bus; drives the board VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of vga_hsync
- VSYNC_POL, 0, asserted level of vga_vsync
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, minimum 4

Ports:
- clock  in  1  single clock for APB and pixel logic
- reset  in  1  asynchronous, active-low reset
- in_paddr  in  32  APB address; bits [4:2] decoded
- in_psel  in  1  APB select
- in_penable  in  1  APB enable
- in_pprot  in  3  ignored
- in_pwrite  in  1  APB write
- in_pwdata  in  32  APB write data
- in_pstrb  in  4  ignored; full-word writes only
- in_pready  out  1  constant 1 (zero wait states)
- in_prdata  out  32  read data, valid in access phase
- in_pslverr  out  1  error response, access phase only
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_valid  out  1  active-video pixel strobe

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Line order is sync, back porch, active, front porch.
- Counters:
  - x counts 0..H_TOTAL-1; y counts 0..V_TOTAL-1.
  - x wraps to 0 and y increments; y wraps to 0 after the last line.
  - Counters run only while CTRL.en=1. With CTRL.en=0 they are held at 0.
- Raw timing:
  - hs_raw = x<H_SYNC; vs_raw = y<V_SYNC.
  - act = (H_SYNC+H_BP <= x < H_SYNC+H_BP+H_ACTIVE) and (V_SYNC+V_BP <= y < V_SYNC+V_BP+V_ACTIVE).
- Outputs are registered with 1-cycle latency: outputs at cycle n+1 reflect (x,y) at cycle n.
  - vga_hsync = hs_raw ? HSYNC_POL : ~HSYNC_POL; vga_vsync likewise with VSYNC_POL.
  - vga_valid = act & en.
  - RGB is 0 whenever vga_valid would be 0.
- en=0 or reset: vga_valid=0, rgb=0, syncs at deasserted level. in_prdata=0, in_pslverr=0.
- Pixel sources, selected by CTRL.mode:
  - 0 solid: COLOR[23:0] as {r,g,b}.
  - 1 bars: 8 bars of width BW=H_ACTIVE/8 (integer division); any remainder pixels use bar 7. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 2 stream: one FIFO entry is popped per active pixel. If the FIFO is empty, output 000000 and increment UNDERFLOW (16-bit, saturates at FFFF).
  - 3: same as 0.
- APB:
  - Register updates occur when psel & penable & pwrite.
  - pslverr=1 for offsets 0x14..0x1C, and for a FIFO push while the FIFO is full. An erroring write changes no state.
- Register map:
  - 0x00 CTRL RW: [0] en, [2:1] mode. Reset 0.
  - 0x04 COLOR RW: [23:0]. Reset 0.
  - 0x08 STATUS:
    - Read fields: [0] vblank (y outside active lines), [1] fifo_full, [2] fifo_empty, [3] frame_done sticky, [15:8] fifo level, [31:16] frame count.
    - Write: writing 1 to bit 3 clears frame_done. All other bits are RO.
  - 0x0C FIFO WO: push in_pwdata[23:0]. Reads return 0.
  - 0x10 UNDERFLOW: RO count; any write clears it to 0.
- Frame events: on the cycle where x=H_TOTAL-1 and y=V_TOTAL-1 with en=1, set frame_done and increment frame count (wraps at 16 bits).
  - A set and a W1C clear in the same cycle: set wins.
- FIFO corner cases:
  - Push and pop in the same cycle with the FIFO full: the full check uses pre-pop state, so the push errors.
  - Same cycle with the FIFO empty: the pop underflows and the push succeeds.
  - The FIFO is flushed when CTRL is written with mode≠2 or en=0.
- Mid-operation changes:
  - Reset mid-frame immediately zeros all state and outputs.
  - Clearing en mid-frame stops and zeros the counters; the next frame starts at x=y=0.

Test Plan:
- Timing: en=1, mode=0 with defaults.
  - Required: hsync low for 96 of every 800 cycles, vsync low for 2 lines of 525.
  - Required: first vga_valid at cycle 1+(35*800+144) after en; 640x480 valid pixels per frame; frame_done set after 420000 cycles.
- Registers:
  - Write COLOR=0x123456 -> read 0x123456; active pixels r=12, g=34, b=56.
  - Access offset 0x14 -> pslverr=1.
  - W1C on STATUS bit 3 clears frame_done.
- Bars: mode=1 -> active-line pixels 0..79 FFFFFF, 80..159 FFFF00, ..., 560..639 000000.
- Stream and FIFO limits:
  - Push 16 words -> fifo_full=1; a 17th push -> pslverr=1, level stays 16.
  - mode=2 -> first active pixels show the pushed words in order.
  - Starved line -> 000000 output, UNDERFLOW counts each starved pixel; a write clears it.
- Reset mid-frame: assert reset at x=300,y=200 -> all outputs and registers at reset values within the same cycle; counters restart at 0 after release and en is set.
- Polarity: HSYNC_POL=1, VSYNC_POL=1 -> sync pulses high, widths unchanged.

Source files
------------

// File: rtl/vga_ctrl_apb.sv
// VGA timing generator and pixel source (solid, colour bars, FIFO stream) with an APB3 control port.
// All outputs are registered one cycle behind the (x, y) counters that produce them.
module vga_ctrl_apb #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_valid
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int XW      = $clog2(H_TOTAL + 1);
    localparam int YW      = $clog2(V_TOTAL + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BW      = H_ACTIVE / 8;

    localparam logic [XW-1:0] H_SYNC_X  = XW'(H_SYNC);
    localparam logic [XW-1:0] H_START_X = XW'(H_SYNC + H_BP);
    localparam logic [XW-1:0] H_END_X   = XW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [XW-1:0] H_LAST_X  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_SYNC_Y  = YW'(V_SYNC);
    localparam logic [YW-1:0] V_START_Y = YW'(V_SYNC + V_BP);
    localparam logic [YW-1:0] V_END_Y   = YW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [YW-1:0] V_LAST_Y  = YW'(V_TOTAL - 1);
    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [XW-1:0] x, x_off;
    logic [YW-1:0] y;
    logic [2:0]    ctrl;
    logic [23:0]   color;
    logic          frame_done;
    logic [15:0]   frame_cnt, underflow;
    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [2:0]    bar, off;
    logic [23:0]   pixel;
    logic en, hs_raw, vs_raw, act, vblank, frame_end;
    logic fifo_full, fifo_empty, pop_req, pop, starve, push, flush;
    logic access, bad_off, err, wr_ok;
    logic [1:0] mode;
    logic unused_bits;

    assign unused_bits = ^{in_pprot, in_pstrb, in_paddr[31:5], in_paddr[1:0], in_pwdata[31:24]};

    assign en         = ctrl[0];
    assign mode       = ctrl[2:1];
    assign off        = in_paddr[4:2];
    assign access     = in_psel & in_penable;
    assign fifo_full  = (level == FULL_LVL);
    assign fifo_empty = (level == '0);
    // A push is judged against the pre-pop fill level, so a full FIFO rejects it even if a pop happens.
    assign bad_off    = (off >= 3'd5);
    assign err        = access & (bad_off | (in_pwrite & (off == 3'd3) & fifo_full));
    assign wr_ok      = access & in_pwrite & ~err;
    assign push       = wr_ok & (off == 3'd3);
    assign flush      = wr_ok & (off == 3'd0) & ((in_pwdata[2:1] != 2'd2) | ~in_pwdata[0]);

    assign hs_raw    = (x < H_SYNC_X);
    assign vs_raw    = (y < V_SYNC_Y);
    assign vblank    = ~((y >= V_START_Y) & (y < V_END_Y));
    assign act       = (x >= H_START_X) & (x < H_END_X) & ~vblank;
    assign frame_end = en & (x == H_LAST_X) & (y == V_LAST_Y);
    assign pop_req   = en & act & (mode == 2'd2);
    assign pop       = pop_req & ~fifo_empty;
    assign starve    = pop_req & fifo_empty;
    assign x_off     = x - H_START_X;

    // Remainder pixels past 8*BW fall through to bar 7.
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x_off >= XW'(i * BW)) bar = 3'(i);
        end
    end

    always_comb begin
        pixel = color;
        case (mode)
            2'd1:    pixel = bar_rgb(bar);
            2'd2:    pixel = fifo_empty ? 24'h0 : fifo_mem[rd_ptr];
            default: pixel = color;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (!en) begin
            x <= '0;
            y <= '0;
        end else if (x == H_LAST_X) begin
            x <= '0;
            y <= (y == V_LAST_Y) ? '0 : y + 1'b1;
        end else begin
            x <= x + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vga_hsync       <= ~HSYNC_POL;
            vga_vsync       <= ~VSYNC_POL;
            vga_valid       <= 1'b0;
            {vga_r, vga_g, vga_b} <= 24'h0;
        end else begin
            vga_hsync       <= (en & hs_raw) ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync       <= (en & vs_raw) ? VSYNC_POL : ~VSYNC_POL;
            vga_valid       <= en & act;
            {vga_r, vga_g, vga_b} <= (en & act) ? pixel : 24'h0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl       <= '0;
            color      <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            underflow  <= '0;
        end else begin
            if (wr_ok && off == 3'd0) ctrl  <= in_pwdata[2:0];
            if (wr_ok && off == 3'd1) color <= in_pwdata[23:0];
            if (frame_end) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
            end else if (wr_ok && off == 3'd2 && in_pwdata[3]) begin
                frame_done <= 1'b0;
            end
            if (wr_ok && off == 3'd4) underflow <= '0;
            else if (starve)          underflow <= sat_inc16(underflow);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= in_pwdata[23:0];
    end

    assign in_pready  = 1'b1;
    assign in_pslverr = reset & err;

    always_comb begin
        in_prdata = 32'h0;
        if (reset && access && !in_pwrite) begin
            case (off)
                3'd0:    in_prdata = {29'h0, ctrl};
                3'd1:    in_prdata = {8'h0, color};
                3'd2:    in_prdata = {frame_cnt, 8'(level), 4'h0, frame_done, fifo_empty, fifo_full, vblank};
                3'd4:    in_prdata = {16'h0, underflow};
                default: in_prdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_ctrl_apb.sv
// Directed bench for vga_ctrl_apb on a shrunken 28x9 raster (20x4 active), plus an inverted-polarity copy.
module tb_vga_ctrl_apb;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  pprot = '0;
    logic [3:0]  pstrb = 4'hF;
    logic        pready, pslverr, p_pready, p_pslverr;
    logic [31:0] prdata, p_prdata;
    logic [7:0]  r, g, b, p_r, p_g, p_b;
    logic        hsync, vsync, valid, p_hsync, p_vsync, p_valid;

    int vectors = 0, miscompares = 0;
    int first_m, valid_cnt, hs_act, vs_act, hs_act_pol, vs_act_pol, idle_rgb;
    logic [23:0] pix[$];
    logic [31:0] rd;
    logic        err;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    vga_ctrl_apb #(.H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut (
        .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel), .in_penable(penable),
        .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(pready), .in_prdata(prdata), .in_pslverr(pslverr),
        .vga_r(r), .vga_g(g), .vga_b(b), .vga_hsync(hsync), .vga_vsync(vsync), .vga_valid(valid));

    vga_ctrl_apb #(.H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut_pol (
        .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel), .in_penable(penable),
        .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(p_pready), .in_prdata(p_prdata), .in_pslverr(p_pslverr),
        .vga_r(p_r), .vga_g(p_g), .vga_b(p_b), .vga_hsync(p_hsync), .vga_vsync(p_vsync), .vga_valid(p_valid));

    always #5 clock = ~clock;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic e);
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(posedge clock); #1;
        penable = 1'b1;
        #1 e = pslverr;
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic e);
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(posedge clock); #1;
        penable = 1'b1;
        #1 begin data = prdata; e = pslverr; end
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Sample n cycles after the current edge; m=1 shows raster position 0.
    task automatic capture(input int n);
        first_m = -1; valid_cnt = 0; hs_act = 0; vs_act = 0;
        hs_act_pol = 0; vs_act_pol = 0; idle_rgb = 0;
        pix.delete();
        for (int m = 1; m <= n; m++) begin
            @(posedge clock); #1;
            if (valid) begin
                if (first_m < 0) first_m = m;
                valid_cnt++;
                if (pix.size() < 32) pix.push_back({r, g, b});
            end else if ({r, g, b} != 24'h0) begin
                idle_rgb++;
            end
            if (!hsync)  hs_act++;
            if (!vsync)  vs_act++;
            if (p_hsync) hs_act_pol++;
            if (p_vsync) vs_act_pol++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk_vec("rst_valid", 32'(valid), 32'h0);
        chk_vec("rst_rgb", {8'h0, r, g, b}, 32'h0);
        chk_vec("rst_hsync", 32'(hsync), 32'h1);
        chk_vec("rst_vsync", 32'(vsync), 32'h1);
        chk_vec("rst_pol_hsync", 32'(p_hsync), 32'h0);
        chk_vec("pready", 32'(pready), 32'h1);
        reset = 1'b1;

        apb_read(32'h08, rd, err);
        chk_vec("status_reset", rd, 32'h0000_0005);
        apb_write(32'h04, 32'h0012_3456, err);
        apb_read(32'h04, rd, err);
        chk_vec("color_rd", rd, 32'h0012_3456);
        apb_read(32'h14, rd, err);
        chk_vec("err_0x14", 32'(err), 32'h1);
        apb_write(32'h1C, 32'h1, err);
        chk_vec("err_0x1c", 32'(err), 32'h1);
        apb_read(32'h00, rd, err);
        chk_vec("ctrl_after_err", rd, 32'h0);
        chk_vec("ctrl_rd_ok", 32'(err), 32'h0);
        apb_read(32'h0C, rd, err);
        chk_vec("fifo_rd_zero", rd, 32'h0);

        // Full frame, solid colour: 28x9 raster, 20x4 active, first active at y=4,x=6.
        apb_write(32'h00, 32'h1, err);
        capture(252);
        chk_vec("first_valid", 32'(first_m), 32'd119);
        chk_vec("valid_cnt", 32'(valid_cnt), 32'd80);
        chk_vec("hsync_low", 32'(hs_act), 32'd27);
        chk_vec("vsync_low", 32'(vs_act), 32'd56);
        chk_vec("pol_hsync_high", 32'(hs_act_pol), 32'd27);
        chk_vec("pol_vsync_high", 32'(vs_act_pol), 32'd56);
        chk_vec("idle_rgb_zero", 32'(idle_rgb), 32'd0);
        chk_vec("solid_pixel", {8'h0, pix[0]}, 32'h0012_3456);
        apb_read(32'h08, rd, err);
        chk_vec("status_frame", rd, 32'h0001_000D);
        apb_write(32'h08, 32'h8, err);
        apb_read(32'h08, rd, err);
        chk_vec("status_w1c", rd, 32'h0001_0005);

        // Colour bars: BW=2, remainder pixels 16..19 stay on bar 7.
        apb_write(32'h00, 32'h0, err);
        apb_write(32'h00, 32'h3, err);
        capture(140);
        chk_vec("bars_cnt", 32'(valid_cnt), 32'd20);
        for (int i = 0; i < 20; i++)
            chk_vec($sformatf("bar_px%0d", i), {8'h0, pix[i]}, {8'h0, bars[(i / 2 > 7) ? 7 : i / 2]});

        // Stream: fill FIFO, overflow, then drain on one line with 4 starved pixels.
        apb_write(32'h00, 32'h0, err);
        for (int i = 0; i < 16; i++) begin
            apb_write(32'h0C, 32'h00A0_0000 | 32'(i), err);
            chk_vec($sformatf("push%0d_err", i), 32'(err), 32'h0);
        end
        apb_read(32'h08, rd, err);
        chk_vec("status_full", rd, 32'h0001_1003);
        apb_write(32'h0C, 32'h00BB_BBBB, err);
        chk_vec("push17_err", 32'(err), 32'h1);
        apb_read(32'h08, rd, err);
        chk_vec("status_full2", rd, 32'h0001_1003);
        apb_write(32'h00, 32'h5, err);
        capture(138);
        chk_vec("stream_cnt", 32'(valid_cnt), 32'd20);
        for (int i = 0; i < 20; i++)
            chk_vec($sformatf("stream_px%0d", i), {8'h0, pix[i]}, (i < 16) ? (32'h00A0_0000 | 32'(i)) : 32'h0);
        apb_write(32'h00, 32'h0, err);
        apb_read(32'h10, rd, err);
        chk_vec("underflow", rd, 32'd4);
        apb_write(32'h10, 32'hFFFF, err);
        apb_read(32'h10, rd, err);
        chk_vec("underflow_clr", rd, 32'd0);

        // Reset in the middle of active video.
        apb_write(32'h00, 32'h1, err);
        capture(125);
        chk_vec("pre_rst_valid", 32'(valid), 32'h1);
        chk_vec("pre_rst_rgb", {8'h0, r, g, b}, 32'h0012_3456);
        reset = 1'b0;
        #2;
        chk_vec("mid_rst_valid", 32'(valid), 32'h0);
        chk_vec("mid_rst_rgb", {8'h0, r, g, b}, 32'h0);
        chk_vec("mid_rst_hsync", 32'(hsync), 32'h1);
        chk_vec("mid_rst_vsync", 32'(vsync), 32'h1);
        chk_vec("mid_rst_pol_vsync", 32'(p_vsync), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        apb_read(32'h00, rd, err);
        chk_vec("post_rst_ctrl", rd, 32'h0);
        apb_read(32'h04, rd, err);
        chk_vec("post_rst_color", rd, 32'h0);
        apb_read(32'h08, rd, err);
        chk_vec("post_rst_status", rd, 32'h0000_0005);
        apb_write(32'h00, 32'h1, err);
        capture(252);
        chk_vec("restart_first_valid", 32'(first_m), 32'd119);
        chk_vec("restart_valid_cnt", 32'(valid_cnt), 32'd80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
